// File: rtl/demux_1_to_8_deser.sv
// Purpose : 1-to-8 deserializer that steers consecutive accepted words into eight parallel lanes.
// Latency : Out_Valid rises the cycle after the 8th accepted word; ack reopens input the next cycle.
// Backpres: In_Ready drops while a complete frame is held; frame stays frozen until Out_Ack.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   In_Valid/In_Ready      word handshake; Data_In is the word, Frame_Sync marks word 0
//   Out_Valid/Out_Ack      complete frame on Data_0..Data_7, consumer acknowledge
//   Write_Index            lane the next accepted word lands in
//   Data_0..Data_7         parallel lanes, Data_k = k-th word of the frame
module demux_1_to_8_deser #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [N_BITS-1:0] Data_In,
    input  logic              Frame_Sync,
    output logic              Out_Valid,
    input  logic              Out_Ack,
    output logic [2:0]        Write_Index,
    output logic [N_BITS-1:0] Data_0,
    output logic [N_BITS-1:0] Data_1,
    output logic [N_BITS-1:0] Data_2,
    output logic [N_BITS-1:0] Data_3,
    output logic [N_BITS-1:0] Data_4,
    output logic [N_BITS-1:0] Data_5,
    output logic [N_BITS-1:0] Data_6,
    output logic [N_BITS-1:0] Data_7
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [2:0]        wr_idx;
    logic [N_BITS-1:0] lane [8];

    // In_Ready is decoded from state only, so accept never sees a combinational
    // path from the consumer side.
    assign accept = In_Valid & In_Ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A sync word landing when the index is 7 restarts the
    // frame at lane 0 instead of completing it.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && !Frame_Sync && (wr_idx == 3'd7)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (Out_Ack) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        case (state)
            FILL:    In_Ready  = 1'b1;
            HOLD:    Out_Valid = 1'b1;
            default: In_Ready  = 1'b0;
        endcase
    end

    // Lane write path. Only accepted words touch the lanes, and accept is
    // impossible in HOLD, so the frame is frozen there. Lanes are never
    // cleared on resync or ack; stale words persist until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                lane[k] <= '0;
            end
        end else if (accept) begin
            if (Frame_Sync) begin
                lane[0] <= Data_In;
                wr_idx  <= 3'd1;
            end else begin
                lane[wr_idx] <= Data_In;
                wr_idx       <= wr_idx + 3'd1;
            end
        end
    end

    assign Write_Index = wr_idx;
    assign Data_0      = lane[0];
    assign Data_1      = lane[1];
    assign Data_2      = lane[2];
    assign Data_3      = lane[3];
    assign Data_4      = lane[4];
    assign Data_5      = lane[5];
    assign Data_6      = lane[6];
    assign Data_7      = lane[7];

endmodule

// File: tb/tb_demux_1_to_8_deser.sv
// Purpose : self-checking bench for demux_1_to_8_deser, directed scenarios plus random traffic.
// Latency : outputs compared 1 ns after each rising edge; inputs changed at the same point.
// Backpres: reference model tracks the held frame and refuses words until it is acked.
module tb_demux_1_to_8_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] Data_In;
    logic       Frame_Sync;
    logic       Out_Valid;
    logic       Out_Ack;
    logic [2:0] Write_Index;
    logic [7:0] Data_0, Data_1, Data_2, Data_3, Data_4, Data_5, Data_6, Data_7;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame under construction as an array of words,
    // how many words the current frame holds, and whether a frame is parked.
    logic [7:0] m_lane [8];
    int         m_cnt;
    bit         m_hold;

    demux_1_to_8_deser #(.N_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Data_In    (Data_In),
        .Frame_Sync (Frame_Sync),
        .Out_Valid  (Out_Valid),
        .Out_Ack    (Out_Ack),
        .Write_Index(Write_Index),
        .Data_0     (Data_0),
        .Data_1     (Data_1),
        .Data_2     (Data_2),
        .Data_3     (Data_3),
        .Data_4     (Data_4),
        .Data_5     (Data_5),
        .Data_6     (Data_6),
        .Data_7     (Data_7)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dut_lane(input int k);
        case (k)
            0: return Data_0;
            1: return Data_1;
            2: return Data_2;
            3: return Data_3;
            4: return Data_4;
            5: return Data_5;
            6: return Data_6;
            default: return Data_7;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, then
    // leave time 1 ns past the edge so callers can sample outputs.
    task automatic step(input bit v, input logic [7:0] d, input bit s, input bit a, input bit r);
        In_Valid   = v;
        Data_In    = d;
        Frame_Sync = s;
        Out_Ack    = a;
        reset      = r;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) m_lane[k] = 8'h00;
            m_cnt  = 0;
            m_hold = 0;
        end else if (m_hold) begin
            if (a) m_hold = 0;
        end else if (v) begin
            if (s) begin
                m_lane[0] = d;
                m_cnt     = 1;
            end else begin
                m_lane[m_cnt] = d;
                m_cnt = m_cnt + 1;
                if (m_cnt == 8) begin
                    m_cnt  = 0;
                    m_hold = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 8'h55, 0, 0, 1);
        step(1, 8'h5A, 1, 0, 1);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'h00) begin
                bad++;
                $display("FAIL reset_lane%0d got=%h want=00", k, dut_lane(k));
            end
        end
        total++;
        if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", Out_Valid); end
        total++;
        if (Write_Index !== 3'd0) begin bad++; $display("FAIL reset_write_index got=%0d want=0", Write_Index); end
        step(0, 8'h00, 0, 0, 0);
        total++;
        if (In_Ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", In_Ready); end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 8; k++) begin
            step(1, 8'(8'h10 + k), (k == 0), 0, 0);
            if (k == 6) begin
                total++;
                if (Out_Valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", Out_Valid); end
            end
        end
        total++;
        if (Out_Valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", Out_Valid); end
        total++;
        if (In_Ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_held got=%b want=0", In_Ready); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'(8'h10 + k)) begin
                bad++;
                $display("FAIL basic_lane%0d got=%h want=%h", k, dut_lane(k), 8'(8'h10 + k));
            end
        end
        step(0, 8'h00, 0, 1, 0);
        total++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack got rdy=%b vld=%b want rdy=1 vld=0", In_Ready, Out_Valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held [8];
        for (int k = 0; k < 8; k++) begin
            held[k] = 8'($urandom_range(0, 255));
            step(1, held[k], (k == 0), 0, 0);
        end
        for (int c = 0; c < 10; c++) begin
            step(1, 8'hAA, c[0], 0, 0);
            total++;
            if (Write_Index !== 3'd0 || Out_Valid !== 1'b1 || In_Ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_c%0d got idx=%0d vld=%b rdy=%b want idx=0 vld=1 rdy=0",
                         c, Write_Index, Out_Valid, In_Ready);
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== held[k]) begin
                bad++;
                $display("FAIL bp_frozen_lane%0d got=%h want=%h", k, dut_lane(k), held[k]);
            end
        end
        step(0, 8'h00, 0, 1, 0);
        for (int k = 0; k < 8; k++) step(1, 8'(8'h20 + k), 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'(8'h20 + k)) begin
                bad++;
                $display("FAIL bp_next_lane%0d got=%h want=%h", k, dut_lane(k), 8'(8'h20 + k));
            end
        end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_gapped();
        int accepted = 0;
        for (int c = 0; c < 16; c++) begin
            bit v = (c % 2 == 0);
            step(v, v ? 8'(8'h30 + accepted) : 8'hEE, 0, 0, 0);
            if (v) accepted++;
            if (accepted < 8) begin
                total++;
                if (Write_Index !== 3'(accepted) || Out_Valid !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_c%0d got idx=%0d vld=%b want idx=%0d vld=0",
                             c, Write_Index, Out_Valid, accepted);
                end
            end
        end
        total++;
        if (Out_Valid !== 1'b1 || Write_Index !== 3'd0) begin
            bad++;
            $display("FAIL gap_done got vld=%b idx=%0d want vld=1 idx=0", Out_Valid, Write_Index);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'(8'h30 + k)) begin
                bad++;
                $display("FAIL gap_lane%0d got=%h want=%h", k, dut_lane(k), 8'(8'h30 + k));
            end
        end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_resync();
        for (int k = 0; k < 3; k++) step(1, 8'(8'h40 + k), 0, 0, 0);
        step(1, 8'h50, 1, 0, 0);
        total++;
        if (Write_Index !== 3'd1) begin bad++; $display("FAIL resync_index got=%0d want=1", Write_Index); end
        for (int k = 1; k < 8; k++) begin
            step(1, 8'(8'h50 + k), 0, 0, 0);
            if (k == 4) begin
                total++;
                if (Out_Valid !== 1'b0) begin bad++; $display("FAIL resync_early_valid got=%b want=0", Out_Valid); end
            end
        end
        total++;
        if (Out_Valid !== 1'b1) begin bad++; $display("FAIL resync_out_valid got=%b want=1", Out_Valid); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'(8'h50 + k)) begin
                bad++;
                $display("FAIL resync_lane%0d got=%h want=%h", k, dut_lane(k), 8'(8'h50 + k));
            end
        end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) step(1, 8'(8'h60 + k), 0, 0, 0);
        step(1, 8'h99, 0, 0, 1);
        total++;
        if (Write_Index !== 3'd0 || Out_Valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ctrl got idx=%0d vld=%b want idx=0 vld=0", Write_Index, Out_Valid);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'h00) begin
                bad++;
                $display("FAIL rstmid_lane%0d got=%h want=00", k, dut_lane(k));
            end
        end
        for (int k = 0; k < 8; k++) step(1, 8'(8'h70 + k), 0, 0, 0);
        total++;
        if (Out_Valid !== 1'b1) begin bad++; $display("FAIL rstmid_next_valid got=%b want=1", Out_Valid); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (dut_lane(k) !== 8'(8'h70 + k)) begin
                bad++;
                $display("FAIL rstmid_next_lane%0d got=%h want=%h", k, dut_lane(k), 8'(8'h70 + k));
            end
        end
        step(0, 8'h00, 0, 1, 0);
    endtask

    // Random traffic against the model: stalls, stray syncs, early/late acks,
    // acks in FILL, and rare resets.
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit         v = ($urandom_range(0, 3) != 0);
            bit         s = ($urandom_range(0, 9) == 0);
            bit         a = ($urandom_range(0, 2) == 0);
            bit         r = ($urandom_range(0, 149) == 0);
            logic [7:0] d = 8'($urandom);
            step(v, d, s, a, r);
            total++;
            if (In_Ready !== !m_hold || Out_Valid !== m_hold || Write_Index !== 3'(m_cnt)) begin
                bad++;
                $display("FAIL rand_ctrl_c%0d got rdy=%b vld=%b idx=%0d want rdy=%b vld=%b idx=%0d",
                         c, In_Ready, Out_Valid, Write_Index, !m_hold, m_hold, m_cnt);
            end
            for (int k = 0; k < 8; k++) begin
                total++;
                if (dut_lane(k) !== m_lane[k]) begin
                    bad++;
                    $display("FAIL rand_lane%0d_c%0d got=%h want=%h", k, c, dut_lane(k), m_lane[k]);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        In_Valid   = 1'b0;
        Data_In    = 8'h00;
        Frame_Sync = 1'b0;
        Out_Ack    = 1'b0;
        for (int k = 0; k < 8; k++) m_lane[k] = 8'h00;
        m_cnt  = 0;
        m_hold = 0;

        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_resync();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
